// File: rtl/fft8_input_framer.sv
// Input framer for the 8-point FFT core: collects 8 complex samples per frame into a
// ping-pong buffer and presents the held frame as packed parallel buses.
`timescale 1ns/1ps

module fft8_input_framer #(
  parameter int DATA_W   = 32,
  parameter bit ZERO_PAD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_real,
  input  logic [DATA_W-1:0]   s_imag,
  input  logic                s_last,
  output logic                frm_valid,
  input  logic                frm_ready,
  output logic [8*DATA_W-1:0] frm_real,
  output logic [8*DATA_W-1:0] frm_imag,
  output logic                err_short,
  output logic [15:0]         frm_count
);

  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d;
  logic              rd_sel_q, rd_sel_d;
  logic [2:0]        wr_idx_q, wr_idx_d;
  logic              err_short_q, err_short_d;
  logic [15:0]       frm_count_q, frm_count_d;
  logic [DATA_W-1:0] buf_re_q [2][8];
  logic [DATA_W-1:0] buf_re_d [2][8];
  logic [DATA_W-1:0] buf_im_q [2][8];
  logic [DATA_W-1:0] buf_im_d [2][8];

  logic accept, close, early, handoff;

  assign s_ready   = ~full_q[wr_sel_q];
  assign frm_valid = full_q[rd_sel_q];
  assign err_short = err_short_q;
  assign frm_count = frm_count_q;

  assign accept  = s_valid & s_ready;
  assign early   = accept & ZERO_PAD & s_last & (wr_idx_q != 3'd7);
  assign close   = accept & ((wr_idx_q == 3'd7) | (ZERO_PAD & s_last));
  assign handoff = frm_valid & frm_ready;

  // NOTE: every _d gets its hold value before any branch, so no path leaves a latch.
  always_comb begin
    full_d      = full_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_idx_d    = wr_idx_q;
    frm_count_d = frm_count_q;
    err_short_d = early;
    buf_re_d    = buf_re_q;
    buf_im_d    = buf_im_q;

    if (accept) begin
      buf_re_d[wr_sel_q][wr_idx_q] = s_real;
      buf_im_d[wr_sel_q][wr_idx_q] = s_imag;
      wr_idx_d = wr_idx_q + 3'd1;
    end

    if (early) begin
      for (int k = 0; k < 8; k++) begin
        if (k > int'(wr_idx_q)) begin
          buf_re_d[wr_sel_q][k] = '0;
          buf_im_d[wr_sel_q][k] = '0;
        end
      end
    end

    // Close and hand-off always target different buffers, so both flag updates stand.
    if (close) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
      wr_idx_d         = 3'd0;
    end

    if (handoff) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
      frm_count_d      = frm_count_q + 16'd1;
    end
  end

  // NOTE: the sample buffers are cleared on reset so a stale frame can never be presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q      <= 2'b00;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_idx_q    <= 3'd0;
      err_short_q <= 1'b0;
      frm_count_q <= 16'd0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 8; k++) begin
          buf_re_q[b][k] <= '0;
          buf_im_q[b][k] <= '0;
        end
      end
    end else begin
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      wr_idx_q    <= wr_idx_d;
      err_short_q <= err_short_d;
      frm_count_q <= frm_count_d;
      buf_re_q    <= buf_re_d;
      buf_im_q    <= buf_im_d;
    end
  end

  always_comb begin
    frm_real = '0;
    frm_imag = '0;
    for (int k = 0; k < 8; k++) begin
      frm_real[k*DATA_W +: DATA_W] = buf_re_q[rd_sel_q][k];
      frm_imag[k*DATA_W +: DATA_W] = buf_im_q[rd_sel_q][k];
    end
  end

endmodule

// File: tb/tb_fft8_input_framer.sv
// Scoreboard bench for fft8_input_framer: the driver queues each expected frame as it
// closes; a monitor pops and compares on every observed frame hand-off.
`timescale 1ns/1ps

module tb_fft8_input_framer;

  typedef struct {
    logic [255:0] re;
    logic [255:0] im;
  } frame_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_real, s_imag;
  logic         frm_valid, frm_ready;
  logic [255:0] frm_real, frm_imag;
  logic         err_short;
  logic [15:0]  frm_count;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  int err_seen = 0;
  int exp_err  = 0;

  frame_t      sb[$];
  logic [31:0] m_re [8];
  logic [31:0] m_im [8];
  int          m_idx = 0;

  always #5 clk = ~clk;

  fft8_input_framer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_real    (s_real),
    .s_imag    (s_imag),
    .s_last    (s_last),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .frm_real  (frm_real),
    .frm_imag  (frm_imag),
    .err_short (err_short),
    .frm_count (frm_count)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame assembly: natural order, zero-fill after an early last.
  task automatic model_accept(input logic [31:0] re, input logic [31:0] im, input logic last);
    frame_t f;
    m_re[m_idx] = re;
    m_im[m_idx] = im;
    if (m_idx == 7 || last) begin
      if (m_idx < 7) exp_err++;
      for (int k = m_idx + 1; k < 8; k++) begin
        m_re[k] = '0;
        m_im[k] = '0;
      end
      for (int k = 0; k < 8; k++) begin
        f.re[k*32 +: 32] = m_re[k];
        f.im[k*32 +: 32] = m_im[k];
      end
      sb.push_back(f);
      m_idx = 0;
    end else begin
      m_idx++;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the sample.
  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
    int guard = 0;
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    s_last  = last;
    @(negedge clk);
    if (!s_ready) stall_cnt++;
    while (!s_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      check("s_ready_timeout", 256'(s_ready), 256'(1));
    end else begin
      model_accept(re, im, last);
      @(posedge clk);
    end
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge clk);
      if (!rst && err_short) err_seen++;
      if (!rst && frm_valid && frm_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 256'(frm_valid), 256'(0));
        end else begin
          f = sb.pop_front();
          check("frame_real", frm_real, f.re);
          check("frame_imag", frm_imag, f.im);
        end
      end
    end
  end

  initial begin : stim
    int guard;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_real = '0; s_imag = '0; frm_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_frm_valid", 256'(frm_valid), 256'(0));
    check("rst_err_short", 256'(err_short), 256'(0));
    check("rst_frm_count", 256'(frm_count), 256'(0));
    check("rst_s_ready",   256'(s_ready),   256'(1));
    check("rst_frm_real",  frm_real,        256'(0));
    tick();

    // Single frame, consumer ready: one-cycle frm_valid.
    frm_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(32'(k), 32'(-k), 1'b0);
    @(negedge clk);
    check("t1_valid_hi", 256'(frm_valid), 256'(1));
    @(negedge clk);
    check("t1_valid_lo", 256'(frm_valid), 256'(0));
    check("t1_count",    256'(frm_count), 256'(1));
    tick();

    // Consumer stalled: two frames fill both buffers, 17th sample waits.
    frm_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(32'(100 + k), 32'(200 + k), 1'b0);
    @(negedge clk);
    check("t2_both_full_s_ready", 256'(s_ready), 256'(0));
    check("t2_frm_valid", 256'(frm_valid), 256'(1));
    fork
      send(32'd116, 32'd216, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 frm_ready = 1'b1;
      end
    join
    check("t2_count", 256'(frm_count), 256'(3));
    check("t2_s_ready_back", 256'(s_ready), 256'(1));
    for (int k = 1; k < 8; k++) send(32'(116 + k), 32'(216 + k), 1'b0);

    // Early s_last on the third sample.
    send(32'd300, 32'd310, 1'b0);
    send(32'd301, 32'd311, 1'b0);
    send(32'd302, 32'd312, 1'b1);
    @(negedge clk);
    check("t3_err_hi", 256'(err_short), 256'(1));
    @(negedge clk);
    check("t3_err_lo", 256'(err_short), 256'(0));
    tick();
    for (int k = 0; k < 8; k++) send(32'(400 + k), 32'(410 + k), 1'b0);
    repeat (3) @(negedge clk);
    check("t3_count", 256'(frm_count), 256'(6));
    tick();

    // Continuous streaming for 80 cycles.
    stall_cnt = 0;
    for (int i = 0; i < 80; i++) send(32'(1000 + i), ~32'(i), 1'b0);
    repeat (3) @(negedge clk);
    check("t4_no_stall", 256'(stall_cnt), 256'(0));
    check("t4_count",    256'(frm_count), 256'(16));
    tick();

    // Reset with one full buffer pending and a partial frame.
    frm_ready = 1'b0;
    for (int k = 0; k < 13; k++) send(32'(500 + k), 32'(600 + k), 1'b0);
    rst = 1'b1;
    sb.delete();
    m_idx = 0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_frm_valid", 256'(frm_valid), 256'(0));
    check("t5_s_ready",   256'(s_ready),   256'(1));
    check("t5_count",     256'(frm_count), 256'(0));
    tick();
    frm_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(32'(700 + k), 32'(710 + k), 1'b0);
    repeat (3) @(negedge clk);
    check("t5_count_after", 256'(frm_count), 256'(1));
    tick();

    // Frame counter wrap.
    frm_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(32'(800 + k), 32'(810 + k), 1'b0);
    @(negedge clk);
    check("t6_pending", 256'(frm_valid), 256'(1));
    force dut.frm_count_q = 16'hFFFF;
    #1 release dut.frm_count_q;
    check("t6_forced", 256'(frm_count), 256'(16'hFFFF));
    @(posedge clk);
    #1 frm_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_wrap", 256'(frm_count), 256'(0));

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("sb_drained", 256'(sb.size()), 256'(0));
    check("err_pulses", 256'(err_seen),  256'(exp_err));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
